// File: rtl/cipher_pkg.sv
// Shared definitions for the cipher job scheduler: default sizes, chunk counts
// and the controller state encoding.
package cipher_pkg;

  localparam int DATAW_DEF   = 10;
  localparam int ROUNDS_DEF  = 31;
  localparam int KEY_CHUNKS  = 4;
  localparam int DATA_CHUNKS = 2;
  localparam int CNTW        = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_DATA = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic state_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer remembers the last granted index
// and only moves when a grant is actually taken (req & grant).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_reg;

  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_reg;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
    grant = 2'b00;
    if (en && (req != 2'b00)) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

  // Reset as "last granted = 1" so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg <= 1'b1;
    end else if (|(req & grant)) begin
      last_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/cipher_job_sched.sv
// Arbitrates two requesters onto one cipher core: streams key then data chunks,
// lets the core run ROUNDS cycles, captures the result and returns it.
module cipher_job_sched
  import cipher_pkg::*;
#(
  parameter int DATAW  = DATAW_DEF,
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0][4*DATAW-1:0]       req_key,
  input  logic [1:0][2*DATAW-1:0]       req_data,
  output logic [DATAW-1:0]              keyout,
  output logic [DATAW-1:0]              dataout,
  output logic                          kctr,
  output logic                          dctr,
  output logic                          lfsrset,
  output logic                          core_save,
  input  logic [2*DATAW-1:0]            core_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2*DATAW-1:0]            rsp_data,
  output logic                          rsp_id,
  output logic                          busy
);

  state_t                     state_reg, state_next;
  logic [CNTW-1:0]            cnt_reg, cnt_next;
  logic [4*DATAW-1:0]         key_reg, key_next;
  logic [2*DATAW-1:0]         data_reg, data_next;
  logic                       id_reg, id_next;
  logic [DATAW-1:0]           keyout_next, dataout_next;
  logic                       kctr_next, dctr_next, lfsrset_next, core_save_next;
  logic                       rsp_valid_next, rsp_id_next;
  logic [2*DATAW-1:0]         rsp_data_next;

  logic                       grant_idx;
  logic                       accept;
  logic [DATAW-1:0]           key_chunk  [KEY_CHUNKS];
  logic [DATAW-1:0]           data_chunk [DATA_CHUNKS];

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .en        (state_reg == ST_IDLE),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign accept = |(req_valid & req_ready);
  assign busy   = state_busy(state_reg);

  genvar gi;
  for (gi = 0; gi < KEY_CHUNKS; gi++) begin : g_key_chunk
    assign key_chunk[gi] = key_reg[gi*DATAW +: DATAW];
  end
  for (gi = 0; gi < DATA_CHUNKS; gi++) begin : g_data_chunk
    assign data_chunk[gi] = data_reg[gi*DATAW +: DATAW];
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    key_next       = key_reg;
    data_next      = data_reg;
    id_next        = id_reg;
    keyout_next    = keyout;
    dataout_next   = dataout;
    kctr_next      = kctr;
    dctr_next      = dctr;
    lfsrset_next   = lfsrset;
    core_save_next = 1'b0;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    rsp_id_next    = rsp_id;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          // Chunk 0 comes straight from the request so it is valid right after the handshake.
          state_next   = ST_KEY;
          cnt_next     = '0;
          key_next     = req_key[grant_idx];
          data_next    = req_data[grant_idx];
          id_next      = grant_idx;
          keyout_next  = req_key[grant_idx][DATAW-1:0];
          kctr_next    = 1'b1;
          dctr_next    = 1'b0;
          lfsrset_next = 1'b1;
        end
      end
      ST_KEY: begin
        if (cnt_reg == CNTW'(KEY_CHUNKS-1)) begin
          state_next   = ST_DATA;
          cnt_next     = '0;
          kctr_next    = 1'b0;
          dctr_next    = 1'b1;
          dataout_next = data_chunk[0];
        end else begin
          cnt_next    = cnt_reg + 1'b1;
          keyout_next = key_chunk[cnt_reg[1:0] + 2'd1];
        end
      end
      ST_DATA: begin
        if (cnt_reg == CNTW'(DATA_CHUNKS-1)) begin
          state_next   = ST_RUN;
          cnt_next     = '0;
          dctr_next    = 1'b0;
          lfsrset_next = 1'b0;
        end else begin
          cnt_next     = cnt_reg + 1'b1;
          dataout_next = data_chunk[1];
        end
      end
      ST_RUN: begin
        if (cnt_reg == CNTW'(ROUNDS-1)) begin
          state_next     = ST_RESP;
          cnt_next       = '0;
          rsp_data_next  = core_result;
          rsp_id_next    = id_reg;
          rsp_valid_next = 1'b1;
          core_save_next = 1'b1;
          lfsrset_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      key_reg   <= '0;
      data_reg  <= '0;
      id_reg    <= 1'b0;
      keyout    <= '0;
      dataout   <= '0;
      kctr      <= 1'b0;
      dctr      <= 1'b0;
      lfsrset   <= 1'b1;
      core_save <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      key_reg   <= key_next;
      data_reg  <= data_next;
      id_reg    <= id_next;
      keyout    <= keyout_next;
      dataout   <= dataout_next;
      kctr      <= kctr_next;
      dctr      <= dctr_next;
      lfsrset   <= lfsrset_next;
      core_save <= core_save_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_id    <= rsp_id_next;
    end
  end

endmodule
